// File: rtl/disp_arbiter.sv
// Display content arbiter: background value A vs. timed req/ack message B for a 4-digit scanner.
// Optional build macro DISP_ARB_LZB_EN enables leading-zero blanking of the background.
`timescale 1ns/1ps
module disp_arbiter #(
  parameter int TICK_DIV = 50000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a_num,
  input  logic        a_blink,
  input  logic        b_req,
  input  logic [15:0] b_num,
  input  logic        b_cancel,
  output logic        b_ack,
  output logic        b_done,
  output logic        busy,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  localparam logic [1:0] SHOW_A = 2'd0;
  localparam logic [1:0] SHOW_B = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg;
  logic [HW-1:0] hold_reg, hold_next;
  logic [BW-1:0] blink_cnt_reg;
  logic          hidden_reg;
  logic [15:0]   msg_reg, msg_next;
  logic [15:0]   num_reg, num_next;
  logic          ack_reg, ack_next, done_reg, done_next, busy_reg, busy_next;
  logic          tick;
  logic [15:0]   a_san, b_san, a_shown, bg;

  assign tick = (tick_cnt_reg == TICK_LAST);

  // Codes 12..15 are exactly the values with both top bits set; they show as blank.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_san
      assign a_san[gi*4 +: 4] = (a_num[gi*4+2 +: 2] == 2'b11) ? 4'd10 : a_num[gi*4 +: 4];
      assign b_san[gi*4 +: 4] = (b_num[gi*4+2 +: 2] == 2'b11) ? 4'd10 : b_num[gi*4 +: 4];
    end
  endgenerate

`ifdef DISP_ARB_LZB_EN
  logic z4, z3, z2;
  assign z4 = (a_num[15:12] == 4'd0);
  assign z3 = z4 && (a_num[11:8] == 4'd0);
  assign z2 = z3 && (a_num[7:4] == 4'd0);
  assign a_shown = {z4 ? 4'd10 : a_san[15:12],
                    z3 ? 4'd10 : a_san[11:8],
                    z2 ? 4'd10 : a_san[7:4],
                    a_san[3:0]};
`else
  assign a_shown = a_san;
`endif

  assign bg = (a_blink && hidden_reg) ? 16'hAAAA : a_shown;

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    hold_next  = hold_reg;
    ack_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      SHOW_A: if (b_req) begin
        state_next = SHOW_B;
        msg_next   = b_san;
        hold_next  = '0;
        ack_next   = 1'b1;
      end
      SHOW_B: if (b_cancel) begin
        state_next = SHOW_A;
      end else if (tick) begin
        hold_next = hold_reg + 1'b1;
        if (hold_reg == HOLD_LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      DONE:    state_next = SHOW_A;
      default: state_next = SHOW_A;
    endcase
    // Outputs follow the state being entered, so every transition takes effect at its own edge.
    busy_next = (state_next != SHOW_A);
    num_next  = (state_next == SHOW_A) ? bg : msg_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= SHOW_A;
      tick_cnt_reg  <= '0;
      hold_reg      <= '0;
      blink_cnt_reg <= '0;
      hidden_reg    <= 1'b0;
      msg_reg       <= 16'hAAAA;
      num_reg       <= 16'hAAAA;
      ack_reg       <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      if (tick) begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg <= '0;
          hidden_reg    <= ~hidden_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
      state_reg <= state_next;
      hold_reg  <= hold_next;
      msg_reg   <= msg_next;
      num_reg   <= num_next;
      ack_reg   <= ack_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign b_ack  = ack_reg;
  assign b_done = done_reg;
  assign busy   = busy_reg;
  assign num1   = num_reg[3:0];
  assign num2   = num_reg[7:4];
  assign num3   = num_reg[11:8];
  assign num4   = num_reg[15:12];

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed scoreboard bench for disp_arbiter with TICK_DIV=4, HOLD_MS=3, BLINK_MS=2.
`timescale 1ns/1ps
module tb_disp_arbiter;

  localparam int TICK_DIV = 4;
  localparam int HOLD_MS  = 3;
  localparam int BLINK_MS = 2;

`ifdef DISP_ARB_LZB_EN
  localparam logic [15:0] E0042 = 16'hAA42;
  localparam logic [15:0] E0005 = 16'hAAA5;
  localparam logic [15:0] E0000 = 16'hAAA0;
  localparam logic [15:0] E0105 = 16'hA105;
`else
  localparam logic [15:0] E0042 = 16'h0042;
  localparam logic [15:0] E0005 = 16'h0005;
  localparam logic [15:0] E0000 = 16'h0000;
  localparam logic [15:0] E0105 = 16'h0105;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_num, b_num;
  logic        a_blink, b_req, b_cancel;
  logic        b_ack, b_done, busy;
  logic [3:0]  num1, num2, num3, num4;

  always #5 clk = ~clk;

  disp_arbiter #(.TICK_DIV(TICK_DIV), .HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS)) dut (
    .clk(clk), .reset(reset), .a_num(a_num), .a_blink(a_blink),
    .b_req(b_req), .b_num(b_num), .b_cancel(b_cancel),
    .b_ack(b_ack), .b_done(b_done), .busy(busy),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4)
  );

  typedef struct {
    string       tag;
    logic [15:0] num;
    logic        busy;
    logic        ack;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_n = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, expv);
    end
  endtask

  // Background expected while a_num=1234 blinks: one blink half-period is 8 clocks.
  function automatic logic [15:0] blink_exp(input int k);
    return ((((k - 1) / (BLINK_MS * TICK_DIV)) % 2) == 1) ? 16'hAAAA : 16'h1234;
  endfunction

  task automatic step(input string tag, input logic [15:0] en, input logic eb, input logic ea, input logic ed);
    exp_t e;
    e.tag  = tag;
    e.num  = en;
    e.busy = eb;
    e.ack  = ea;
    e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
    e = sb.pop_front();
    $display("cyc %0d %s num=%h busy=%b ack=%b done=%b", cyc_n, e.tag,
             {num4, num3, num2, num1}, busy, b_ack, b_done);
    chk({e.tag, "_num"}, {num4, num3, num2, num1}, e.num);
    chk({e.tag, "_flags"}, {13'b0, busy, b_ack, b_done}, {13'b0, e.busy, e.ack, e.done});
  endtask

  initial begin
    reset = 1'b0; a_num = 16'h0042; a_blink = 1'b0;
    b_req = 1'b0; b_num = 16'h0000; b_cancel = 1'b0;
    #22;
    chk("rst_num", {num4, num3, num2, num1}, 16'hAAAA);
    chk("rst_flags", {13'b0, busy, b_ack, b_done}, 16'h0000);
    @(negedge clk); reset = 1'b1; cyc_n = 0;

    step("t1_bg0042", E0042, 0, 0, 0);
    a_num = 16'h70C9; step("sanitise", 16'h70A9, 0, 0, 0);
    a_num = 16'h0005; step("lzb_units", E0005, 0, 0, 0);
    a_num = 16'h0000; step("lzb_zero", E0000, 0, 0, 0);
    a_num = 16'h0105; step("lzb_inner0", E0105, 0, 0, 0);

    a_num = 16'h0042; b_req = 1'b1; b_num = 16'h12F5;
    step("t2_accept", 16'h12A5, 1, 1, 0);
    b_req = 1'b0; b_num = 16'h9999;
    for (int k = 7; k <= 15; k++) step("t2_hold", 16'h12A5, 1, 0, 0);
    step("t2_done", 16'h12A5, 1, 0, 1);
    step("t2_back", E0042, 0, 0, 0);

    a_num = 16'h1234; a_blink = 1'b1;
    for (int k = 18; k <= 41; k++) step("t3_blink", blink_exp(k), 0, 0, 0);
    b_req = 1'b1; b_num = 16'h0907;
    step("t3_msg_hidden", 16'h0907, 1, 1, 0);
    b_req = 1'b0;
    step("t3_msg_steady", 16'h0907, 1, 0, 0);
    step("t3_msg_steady", 16'h0907, 1, 0, 0);

    b_cancel = 1'b1; a_blink = 1'b0;
    step("t4_cancel", 16'h1234, 0, 0, 0);
    b_cancel = 1'b0;
    for (int k = 46; k <= 56; k++) step("t4_no_done", 16'h1234, 0, 0, 0);
    b_req = 1'b1; b_num = 16'h4321;
    step("t4b_accept", 16'h4321, 1, 1, 0);
    b_req = 1'b0;
    for (int k = 58; k <= 67; k++) step("t4b_hold", 16'h4321, 1, 0, 0);
    b_cancel = 1'b1;
    step("t4b_cancel_expiry", 16'h1234, 0, 0, 0);
    b_cancel = 1'b0;
    step("t4b_after", 16'h1234, 0, 0, 0);
    step("t4b_after", 16'h1234, 0, 0, 0);

    b_req = 1'b1; b_num = 16'h0001;
    step("t5_accept1", 16'h0001, 1, 1, 0);
    for (int k = 72; k <= 79; k++) step("t5_hold_req", 16'h0001, 1, 0, 0);
    step("t5_done", 16'h0001, 1, 0, 1);
    b_num = 16'h0002;
    step("t5_gap", 16'h1234, 0, 0, 0);
    step("t5_accept2", 16'h0002, 1, 1, 0);
    for (int k = 83; k <= 85; k++) step("t5_hold2", 16'h0002, 1, 0, 0);

    #3; reset = 1'b0; #1;
    chk("t6_async_num", {num4, num3, num2, num1}, 16'hAAAA);
    chk("t6_async_flags", {13'b0, busy, b_ack, b_done}, 16'h0000);
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_held_num", {num4, num3, num2, num1}, 16'hAAAA);
    @(negedge clk); reset = 1'b1; cyc_n = 0;
    for (int k = 1; k <= 14; k++) step("t6_after", 16'h1234, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
Content controller that sits in front of the 4-digit scanning 7-segment display driver and produces its num1..num4 digit codes (num1 = units, num4 = thousands; code 10 = blank, code 11 = dash).
Shares the display between two sources:
- Background source A: a free-running value, always valid, with optional blink and leading-zero blanking.
- Message source B: req/ack handshake; the message holds the display for a timed interval, then control returns to A.
Uses a 1 ms tick derived from clk, the same time base as the scan driver.

Parameters:
TICK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz); minimum 2.
HOLD_MS, 2000, ticks a B message stays displayed; minimum 1.
BLINK_MS, 250, ticks per blink half-period; minimum 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
a_num  in  16  background digits: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
a_blink  in  1  1 = background blinks.
b_req  in  1  message request; level, held by the requester until b_ack.
b_num  in  16  message digits, same packing as a_num; sampled only on acceptance.
b_cancel  in  1  abort the message currently shown.
b_ack  out  1  one-cycle pulse: message accepted and latched.
b_done  out  1  one-cycle pulse: hold time expired normally.
busy  out  1  1 while a B message owns the display.
num1, num2, num3, num4  out  4 each  digit codes to the display driver.

Behaviour:
- Reset (async, reset=0):
  - num1..num4 = 10 (all blank); b_ack = 0; b_done = 0; busy = 0.
  - State = SHOW_A; tick, hold and blink counters = 0; blink phase = visible.
- Tick counter: free-running 0..TICK_DIV-1. The tick pulse is high for one cycle when the count equals TICK_DIV-1, and the count then wraps to 0.
- Blink phase: toggles every BLINK_MS ticks, free-running, independent of state.
- All outputs are registered. Latency from an a_num change to num outputs is 1 cycle.
- Digit sanitising: any input digit value 12..15 is displayed as 10. Values 0..11 pass through unchanged.
- State SHOW_A:
  - Outputs are sanitised a_num, with leading-zero blanking applied.
  - If a_blink = 1 and blink phase = hidden, all four outputs are 10.
  - b_req = 1 at an edge: latch sanitised b_num into the message register, drive num outputs from it at the same edge, pulse b_ack, set busy = 1, clear the hold counter, go to SHOW_B.
  - b_cancel is ignored in SHOW_A, including when it coincides with b_req.
- State SHOW_B:
  - Outputs are the latched message, raw: no blanking, no blink.
  - The hold counter increments on each tick.
  - On the tick that brings the hold count to HOLD_MS: go to DONE.
  - Resulting hold duration: (HOLD_MS-1)*TICK_DIV+1 .. HOLD_MS*TICK_DIV cycles after b_ack.
  - b_cancel = 1: next state SHOW_A, busy = 0, no b_done. Cancel wins over a simultaneous expiry.
  - b_req is ignored, no b_ack issued; the requester keeps holding req.
- State DONE (one cycle):
  - Pulse b_done; outputs keep the message.
  - Next state SHOW_A with busy = 0.
  - A b_req sampled in DONE is not accepted; it is accepted the cycle after, in SHOW_A.
- Back-to-back: a pending b_req is accepted on the first SHOW_A cycle, so the background is shown for exactly 1 cycle between messages.
- Reset mid-message: the message is discarded; no b_done or b_ack is generated.
- Leading-zero blanking (with DISP_ARB_LZB_EN):
  - num4 = 10 if the thousands digit is 0.
  - num3 = 10 if num4 is blanked and the hundreds digit is 0.
  - num2 = 10 if num3 is blanked and the tens digit is 0.
  - num1 is never blanked.

Optional Feature:
DISP_ARB_LZB_EN
- Defined: the leading-zero blanking described above applies to the background source.
- Undefined: the background is shown sanitised but unblanked (e.g. 0042 shows as 0,0,4,2), and no blanking logic is synthesised.
- B messages are never blanked in either build.

Test Plan:
(Bench parameters: TICK_DIV=4, HOLD_MS=3, BLINK_MS=2.)
1. Reset, then release with a_num=16'h0042, a_blink=0, LZB_EN defined → after 1 cycle num4=10, num3=10, num2=4, num1=2; busy=0. Without LZB_EN → num4=0, num3=0, num2=4, num1=2.
2. b_req=1, b_num=16'h12F5 in SHOW_A → next edge: b_ack pulse, busy=1, num4=1, num3=2, num2=10, num1=5. b_done pulses 9..12 cycles after b_ack, then num outputs return to the background.
3. a_blink=1, a_num=16'h1234 → outputs alternate between 1,2,3,4 and all-10 every 8 cycles. A message accepted during the hidden phase shows steadily.
4. b_cancel asserted 2 cycles after b_ack → busy=0 and background restored next cycle; b_done never pulses. b_cancel on the expiry tick → no b_done.
5. b_req held high continuously → b_ack pulses once per message, exactly 1 background cycle between DONE and the next b_ack. b_req during SHOW_B → no extra b_ack.
6. reset=0 asserted mid-SHOW_B (asynchronously, between edges) → num1..num4=10 immediately; busy=0; after release, no b_done and the background is displayed.
